alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU for the MIPS core.
- Operand width is generic. Arithmetic SLT is sign-correct. Adds NOR, an unsigned iterative multiply and an optional unsigned iterative divide.
- Operands are accepted and results delivered over a valid/ready handshake, so the pipeline can stall on long operations.
- Sits in the EX stage; the hazard unit watches in_ready/out_valid.

---
 rtl/alu_mc.sv | 279 +++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the MIPS EX stage.
//
// Requests (op, a, b) are accepted on in_valid & in_ready, and results are offered on
// out_valid until out_ready. Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR) and illegal
// ops produce a result one cycle after acceptance. MULU, and DIVU when enabled, iterate
// one bit per cycle and produce a result WIDTH+1 cycles after acceptance.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   block idle and able to accept a request
//   op         4-bit operation code
//   a, b       WIDTH-bit operands
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     low product / quotient / single-cycle result
//   result_hi  high product / remainder, 0 for other ops
//   zero       result == 0
//   ovf        signed overflow for ADD/SUB
//   err        illegal op or divide by zero
//
// Build option: define ALU_MC_DIV_EN to include the unsigned divider (op 1001).
// Without it, op 1001 is answered as an illegal op.

module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpMulu = 4'b1000;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OpDivu = 4'b1001;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    // hi/lo form the iterating pair: partial product + multiplier, or remainder + quotient.
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
`ifdef ALU_MC_DIV_EN
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
`endif

    // Single-cycle datapath, evaluated on the live inputs while idle.
    logic [WIDTH-1:0]   add_res;
    logic [WIDTH-1:0]   sub_res;
    logic               slt_res;
    logic [WIDTH-1:0]   single_res;
    logic               single_ovf;
    logic               single_err;
    logic               start_mul;
`ifdef ALU_MC_DIV_EN
    logic               start_div;
`endif

    assign add_res = a + b;
    assign sub_res = a - b;
    assign slt_res = $signed(a) < $signed(b);

    always_comb begin
        single_res = '0;
        single_ovf = 1'b0;
        single_err = 1'b0;
        start_mul  = 1'b0;
`ifdef ALU_MC_DIV_EN
        start_div  = 1'b0;
`endif
        case (op)
            OpAnd: single_res = a & b;
            OpOr:  single_res = a | b;
            OpAdd: begin
                single_res = add_res;
                single_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                // Subtracting b behaves like adding -b, so the sign test uses ~b's sign.
                single_res = sub_res;
                single_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpSlt: single_res = {{(WIDTH-1){1'b0}}, slt_res};
            OpNor: single_res = ~(a | b);
            OpMulu: start_mul = 1'b1;
`ifdef ALU_MC_DIV_EN
            OpDivu: start_div = 1'b1;
`endif
            default: single_err = 1'b1;
        endcase
    end

    // Shift-add multiply step: add multiplicand when the multiplier LSB is set, then
    // shift {carry, hi, lo} right by one.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi;
    logic [WIDTH-1:0]   mul_lo;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
    // Restoring divide step: shift next dividend bit into the remainder and subtract the
    // divisor if it fits. When it fits, the difference is below b and fits WIDTH bits.
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_hi;
    logic [WIDTH-1:0]   div_lo;

    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_diff  = div_shift[WIDTH-1:0] - b_q;
    assign div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo    = {lo_q[WIDTH-2:0], div_ge};
`endif

    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    always_comb begin
        step_hi = mul_hi;
        step_lo = mul_lo;
`ifdef ALU_MC_DIV_EN
        if (is_div_q) begin
            step_hi = div_hi;
            step_lo = div_lo;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
`ifdef ALU_MC_DIV_EN
        b_d         = b_q;
        is_div_d    = is_div_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d = a;
                    if (start_mul) begin
                        state_d = StBusy;
                        cnt_d   = CNT_W'(WIDTH);
                        hi_d    = '0;
                        lo_d    = b;
`ifdef ALU_MC_DIV_EN
                        b_d      = b;
                        is_div_d = 1'b0;
                    end else if (start_div) begin
                        state_d  = StBusy;
                        cnt_d    = CNT_W'(WIDTH);
                        hi_d     = '0;
                        lo_d     = a;
                        b_d      = b;
                        is_div_d = 1'b1;
`endif
                    end else begin
                        state_d     = StDone;
                        result_d    = single_res;
                        result_hi_d = '0;
                        zero_d      = (single_res == '0);
                        ovf_d       = single_ovf;
                        err_d       = single_err;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                hi_d  = step_hi;
                lo_d  = step_lo;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = StDone;
                    result_d    = step_lo;
                    result_hi_d = step_hi;
                    zero_d      = (step_lo == '0);
                    ovf_d       = 1'b0;
                    err_d       = 1'b0;
`ifdef ALU_MC_DIV_EN
                    // Divide by zero: fixed response, still after the full iteration count.
                    if (is_div_q && (b_q == '0)) begin
                        result_d    = '1;
                        result_hi_d = a_q;
                        zero_d      = 1'b0;
                        err_d       = 1'b1;
                    end
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_MC_DIV_EN
            b_q         <= '0;
            is_div_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
`ifdef ALU_MC_DIV_EN
            b_q         <= b_d;
            is_div_q    <= is_div_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed cases with literal expectations plus
// randomized requests checked every cycle against a behavioural model.

module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = 4'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         ovf;
    logic         err;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
        logic         err;
        int           lat;
    } exp_t;

    // Reference behaviour from the operation definitions using wide integer arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      s;
        logic [63:0] p;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.res = '0;
        e.hi  = '0;
        e.ovf = 1'b0;
        e.err = 1'b0;
        e.lat = 1;
        case (o)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0010: begin
                s     = sx + sy;
                e.res = s[W-1:0];
                e.ovf = (s != longint'($signed(e.res)));
            end
            4'b0110: begin
                s     = sx - sy;
                e.res = s[W-1:0];
                e.ovf = (s != longint'($signed(e.res)));
            end
            4'b0111: e.res = (sx < sy) ? 1 : 0;
            4'b1100: e.res = ~(x | y);
            4'b1000: begin
                p     = {32'b0, x} * {32'b0, y};
                e.res = p[31:0];
                e.hi  = p[63:32];
                e.lat = W + 1;
            end
`ifdef ALU_MC_DIV_EN
            4'b1001: begin
                e.lat = W + 1;
                if (y == 0) begin
                    e.res = '1;
                    e.hi  = x;
                    e.err = 1'b1;
                end else begin
                    e.res = x / y;
                    e.hi  = x % y;
                end
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Model state: one outstanding request, valid from cycle m_due until handed off.
    bit   m_pending = 1'b0;
    int   m_due     = 0;
    exp_t m_exp;
    int   cyc       = 0;
    bit   ev;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pending = 1'b0;
            end else begin
                if (m_pending && (cyc >= m_due) && out_ready) begin
                    m_pending = 1'b0;
                end else if (!m_pending && in_valid) begin
                    m_exp     = model(op, a, b);
                    m_pending = 1'b1;
                    m_due     = cyc + m_exp.lat;
                end
                cyc++;
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ev = m_pending && (cyc >= m_due);
                check("in_ready", in_ready, !m_pending);
                check("out_valid", out_valid, ev);
                if (ev && out_valid) begin
                    check("result", result, m_exp.res);
                    check("result_hi", result_hi, m_exp.hi);
                    check("zero", zero, m_exp.zero);
                    check("ovf", ovf, m_exp.ovf);
                    check("err", err, m_exp.err);
                end
            end
        end
    end

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold, input bit lit, input logic [W-1:0] lres,
                          input logic [W-1:0] lhi, input logic lzero, input logic lovf,
                          input logic lerr, input int llat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        if (!in_ready) return;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = $urandom;
        b        = $urandom;
        n        = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", out_valid, 1'b1);
        if (lit) begin
            check("lit_latency", n, llat);
            check("lit_result", result, lres);
            check("lit_result_hi", result_hi, lhi);
            check("lit_zero", zero, lzero);
            check("lit_ovf", ovf, lovf);
            check("lit_err", err, lerr);
        end
        repeat (hold) @(negedge clk);
        if (lit && hold > 0) begin
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_result", result, lres);
            check("hold_result_hi", result_hi, lhi);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] ops [9];
    logic [3:0] o_r;

    initial begin
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1001,
                4'b1111};
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_result_hi", result_hi, 32'h0);
        check("rst_zero", zero, 1'b1);
        check("rst_ovf", ovf, 1'b0);
        check("rst_err", err, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 1, 32'h8000_0000, 0, 0, 1, 0, 1);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h1, 0, 0, 0, 0, 1);
        run_op(4'b0111, 32'h1, 32'hFFFF_FFFF, 0, 1, 32'h0, 0, 1, 0, 0, 1);
        run_op(4'b1000, 32'hFFFF_FFFF, 32'h2, 5, 1, 32'hFFFF_FFFE, 32'h1, 0, 0, 0, 33);
        run_op(4'b1100, 32'hF0F0_0000, 32'h0000_0F0F, 0, 1, 32'h0F0F_F0F0, 0, 0, 0, 0, 1);
        run_op(4'b0110, 32'h8000_0000, 32'h1, 1, 1, 32'h7FFF_FFFF, 0, 0, 1, 0, 1);
        run_op(4'b1111, 32'h1234, 32'h5678, 0, 1, 32'h0, 0, 1, 0, 1, 1);
`ifdef ALU_MC_DIV_EN
        run_op(4'b1001, 32'd100, 32'd7, 0, 1, 32'd14, 32'd2, 0, 0, 0, 33);
        run_op(4'b1001, 32'd100, 32'd0, 0, 1, 32'hFFFF_FFFF, 32'd100, 0, 0, 1, 33);
`else
        run_op(4'b1001, 32'd100, 32'd7, 0, 1, 32'h0, 0, 1, 0, 1, 1);
`endif

        // Reset during the tenth BUSY cycle of a multiply.
        while (!in_ready) @(negedge clk);
        op       = 4'b1000;
        a        = $urandom;
        b        = $urandom;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_result", result, 32'h0);
        check("midrst_zero", zero, 1'b1);
        check("midrst_err", err, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(4'b0110, 32'd5, 32'd5, 0, 1, 32'h0, 0, 1, 0, 0, 1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) o_r = 4'($urandom);
            else o_r = ops[$urandom_range(0, 8)];
            run_op(o_r, rnd_operand(), rnd_operand(), $urandom_range(0, 3), 0, '0, '0, 0, 0,
                   0, 0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
